fu_issue_arbiter: RTL and testbench

FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

---
 rtl/fu_issue_arbiter_pkg.sv | 36 +++
 rtl/fu_issue_arbiter_if.sv | 33 +++
 rtl/fu_issue_arbiter_rr_arbiter.sv | 45 ++++
 rtl/fu_issue_arbiter.sv | 84 ++++++++
 tb/tb_fu_issue_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fu_issue_arbiter_pkg.sv
// Shared issue definitions for the functional-unit issue stage.
//   NUM_FU          : number of functional units arbitrated in parallel
//   issue_fu_e      : 2-bit target-FU encoding carried per wavefront slot
//   FU_* bit order  : position of each FU in fu_ready / issue_valid / issue_wfid
//   fu_decode()     : encoding -> FU one-hot (no bit set for an unknown value)
package fu_issue_arbiter_pkg;

  localparam int NUM_FU = 4;

  typedef enum logic [1:0] {
    ISSUE_FU_SIMD_ENCODING = 2'd0,
    ISSUE_FU_SALU_ENCODING = 2'd1,
    ISSUE_FU_LSU_ENCODING  = 2'd2,
    ISSUE_FU_SIMF_ENCODING = 2'd3
  } issue_fu_e;

  // Bit order {simf, lsu, salu, simd}.
  localparam int FU_SIMD = 0;
  localparam int FU_SALU = 1;
  localparam int FU_LSU  = 2;
  localparam int FU_SIMF = 3;

  function automatic logic [NUM_FU-1:0] fu_decode(input logic [1:0] enc);
    logic [NUM_FU-1:0] onehot;
    onehot = '0;
    case (enc)
      ISSUE_FU_SIMD_ENCODING: onehot[FU_SIMD] = 1'b1;
      ISSUE_FU_SALU_ENCODING: onehot[FU_SALU] = 1'b1;
      ISSUE_FU_LSU_ENCODING:  onehot[FU_LSU]  = 1'b1;
      ISSUE_FU_SIMF_ENCODING: onehot[FU_SIMF] = 1'b1;
      default:                onehot          = '0;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Issue-stage bus between the wavefront pool and the FU issue arbiter.
//   wf_ready    : per-wavefront instruction ready to issue
//   wf_fu       : per-wavefront target-FU encoding, slot i at [2i+1:2i]
//   fu_ready    : per-FU can accept, order {simf,lsu,salu,simd}
//   issue_valid : per-FU one-cycle grant pulse
//   issue_wfid  : granted wavefront id per FU, FU k at [k*WFID_W +: WFID_W]
//   issued_mask : OR of all wavefronts granted this cycle
// master = wavefront pool side, slave = arbiter side.
interface fu_issue_arbiter_if
  import fu_issue_arbiter_pkg::*;
#(
  parameter int NUM_WF = 8,
  parameter int WFID_W = $clog2(NUM_WF)
);

  logic [NUM_WF-1:0]        wf_ready;
  logic [2*NUM_WF-1:0]      wf_fu;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU-1:0]        issue_valid;
  logic [NUM_FU*WFID_W-1:0] issue_wfid;
  logic [NUM_WF-1:0]        issued_mask;

  modport master (
    output wf_ready, wf_fu, fu_ready,
    input  issue_valid, issue_wfid, issued_mask
  );

  modport slave (
    input  wf_ready, wf_fu, fu_ready,
    output issue_valid, issue_wfid, issued_mask
  );

endinterface

// File: rtl/fu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker for one functional unit.
//   req       : candidate wavefront vector
//   ptr       : search start index; lowest req index >= ptr wins, else lowest overall
//   grant     : one-hot of the winner (zero when req is empty)
//   grant_id  : index of the winner (zero when req is empty)
//   any_grant : req is non-empty
module rr_arbiter #(
  parameter int NUM_WF = 8,
  parameter int WFID_W = $clog2(NUM_WF)
) (
  input  logic [NUM_WF-1:0] req,
  input  logic [WFID_W-1:0] ptr,
  output logic [NUM_WF-1:0] grant,
  output logic [WFID_W-1:0] grant_id,
  output logic              any_grant
);

  logic              hi_any;
  logic [WFID_W-1:0] hi_id;
  logic [WFID_W-1:0] lo_id;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the loop leaves a signal unassigned and infers a latch.
  always_comb begin
    hi_any    = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    any_grant = 1'b0;
    // Scan downward so the last hit written is the lowest index in each range.
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_grant = 1'b1;
        lo_id     = WFID_W'(i);
        if (i >= int'(ptr)) begin
          hi_any = 1'b1;
          hi_id  = WFID_W'(i);
        end
      end
    end
    grant_id = hi_any ? hi_id : lo_id;
    grant    = '0;
    if (any_grant) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Issue arbiter: picks one ready wavefront per functional unit each cycle,
// round-robin per FU, with registered outputs (one-cycle latency).
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : fu_issue_arbiter_if slave (wf_ready, wf_fu, fu_ready in;
//         issue_valid, issue_wfid, issued_mask out)
module fu_issue_arbiter
  import fu_issue_arbiter_pkg::*;
#(
  parameter int NUM_WF = 8,
  parameter int WFID_W = $clog2(NUM_WF)
) (
  input logic                clk,
  input logic                rst,
  fu_issue_arbiter_if.slave  bus
);

  logic [WFID_W-1:0] rr_ptr   [NUM_FU];
  logic [NUM_WF-1:0] holdoff;
  logic [NUM_FU-1:0] wf_dec   [NUM_WF];
  logic [NUM_WF-1:0] req      [NUM_FU];
  logic [NUM_WF-1:0] grant    [NUM_FU];
  logic [WFID_W-1:0] grant_id [NUM_FU];
  logic [NUM_FU-1:0] any_grant;
  logic [NUM_WF-1:0] winner_mask;

  // Candidate vectors. A wavefront granted last cycle is held off because its
  // wf_ready only drops one cycle after the grant is seen upstream.
  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      wf_dec[i] = fu_decode(bus.wf_fu[2*i +: 2]);
    end
    for (int k = 0; k < NUM_FU; k++) begin
      req[k] = '0;
      for (int i = 0; i < NUM_WF; i++) begin
        req[k][i] = bus.wf_ready[i] & ~holdoff[i] & wf_dec[i][k] & bus.fu_ready[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    rr_arbiter #(
      .NUM_WF (NUM_WF),
      .WFID_W (WFID_W)
    ) u_rr_arbiter (
      .req       (req[k]),
      .ptr       (rr_ptr[k]),
      .grant     (grant[k]),
      .grant_id  (grant_id[k]),
      .any_grant (any_grant[k])
    );
  end

  // Each wavefront targets a single FU, so the per-FU grants never overlap.
  always_comb begin
    winner_mask = '0;
    for (int k = 0; k < NUM_FU; k++) winner_mask |= grant[k];
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it only acts on an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.issue_valid <= '0;
      bus.issue_wfid  <= '0;
      bus.issued_mask <= '0;
      holdoff         <= '0;
      for (int k = 0; k < NUM_FU; k++) rr_ptr[k] <= '0;
    end else begin
      bus.issue_valid <= any_grant;
      bus.issued_mask <= winner_mask;
      holdoff         <= winner_mask;
      for (int k = 0; k < NUM_FU; k++) begin
        // Id and pointer hold when the FU does not grant.
        if (any_grant[k]) begin
          bus.issue_wfid[k*WFID_W +: WFID_W] <= grant_id[k];
          rr_ptr[k] <= (grant_id[k] == WFID_W'(NUM_WF - 1)) ? '0
                                                            : grant_id[k] + WFID_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter with hand-computed expectations.
module tb_fu_issue_arbiter;
  import fu_issue_arbiter_pkg::*;

  localparam int NUM_WF = 8;
  localparam int WFID_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fu_issue_arbiter_if #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) bus ();

  fu_issue_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int slot, input issue_fu_e enc);
    bus.wf_fu[2*slot +: 2] = enc;
  endtask

  function automatic logic [WFID_W-1:0] wfid(input int k);
    return bus.issue_wfid[k*WFID_W +: WFID_W];
  endfunction

  task automatic do_reset();
    rst          = 1'b1;
    bus.wf_ready = '0;
    bus.wf_fu    = '0;
    bus.fu_ready = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.wf_ready = '0;
    bus.wf_fu    = '0;
    bus.fu_ready = '0;

    // Reset state and single SALU grant followed by a holdoff gap.
    do_reset();
    check("rst_valid", 32'(bus.issue_valid), 32'h0);
    check("rst_wfid",  32'(bus.issue_wfid),  32'h0);
    check("rst_mask",  32'(bus.issued_mask), 32'h0);
    check("rst_holdoff", 32'(dut.holdoff), 32'h0);
    set_slot(0, ISSUE_FU_SALU_ENCODING);
    bus.wf_ready = 8'h01;
    bus.fu_ready = 4'hF;
    step();
    check("salu_valid", 32'(bus.issue_valid), 32'b0010);
    check("salu_wfid",  32'(wfid(FU_SALU)),   32'd0);
    check("salu_mask",  32'(bus.issued_mask), 32'h01);
    step();
    check("salu_holdoff_valid", 32'(bus.issue_valid), 32'h0);
    check("salu_holdoff_mask",  32'(bus.issued_mask), 32'h0);
    step();
    check("salu_regrant_valid", 32'(bus.issue_valid), 32'b0010);

    // Round robin over SIMD slots 1,3,6 with pointer wrap.
    do_reset();
    set_slot(1, ISSUE_FU_SIMD_ENCODING);
    set_slot(3, ISSUE_FU_SIMD_ENCODING);
    set_slot(6, ISSUE_FU_SIMD_ENCODING);
    bus.wf_ready = 8'h4A;
    bus.fu_ready = 4'b0001;
    begin
      int exp_seq [6] = '{1, 3, 6, 1, 3, 6};
      for (int n = 0; n < 6; n++) begin
        step();
        check($sformatf("rr_valid_%0d", n), 32'(bus.issue_valid), 32'b0001);
        check($sformatf("rr_wfid_%0d", n),  32'(wfid(FU_SIMD)),   32'(exp_seq[n]));
        check($sformatf("rr_mask_%0d", n),  32'(bus.issued_mask), 32'(1 << exp_seq[n]));
      end
    end

    // Three FUs grant in the same cycle.
    do_reset();
    set_slot(2, ISSUE_FU_LSU_ENCODING);
    set_slot(5, ISSUE_FU_SIMF_ENCODING);
    set_slot(7, ISSUE_FU_SIMD_ENCODING);
    bus.wf_ready = 8'hA4;
    bus.fu_ready = 4'hF;
    step();
    check("multi_valid", 32'(bus.issue_valid), 32'b1101);
    check("multi_mask",  32'(bus.issued_mask), 32'hA4);
    check("multi_wfid",  32'(bus.issue_wfid),  32'hA87);
    step();
    check("multi_gap_valid", 32'(bus.issue_valid), 32'h0);
    check("multi_gap_mask",  32'(bus.issued_mask), 32'h0);
    check("multi_wfid_hold", 32'(bus.issue_wfid),  32'hA87);

    // SIMF back-pressure, then release.
    do_reset();
    set_slot(4, ISSUE_FU_SIMF_ENCODING);
    bus.wf_ready = 8'h10;
    bus.fu_ready = 4'b0111;
    for (int n = 0; n < 3; n++) begin
      step();
      check($sformatf("simf_stall_%0d", n), 32'(bus.issue_valid), 32'h0);
    end
    bus.fu_ready = 4'hF;
    step();
    check("simf_valid", 32'(bus.issue_valid), 32'b1000);
    check("simf_wfid",  32'(wfid(FU_SIMF)),   32'd4);
    check("simf_ptr",   32'(dut.rr_ptr[FU_SIMF]), 32'd5);
    set_slot(2, ISSUE_FU_SIMF_ENCODING);
    set_slot(6, ISSUE_FU_SIMF_ENCODING);
    bus.wf_ready = 8'h54;
    step();
    check("simf_next_wfid", 32'(wfid(FU_SIMF)), 32'd6);

    // Reset collides with a ready LSU candidate; pointer restarts at 0.
    do_reset();
    set_slot(3, ISSUE_FU_LSU_ENCODING);
    set_slot(5, ISSUE_FU_LSU_ENCODING);
    bus.wf_ready = 8'h28;
    bus.fu_ready = 4'hF;
    step();
    check("lsu_pre_wfid", 32'(wfid(FU_LSU)), 32'd3);
    rst = 1'b1;
    step();
    check("lsu_rst_valid", 32'(bus.issue_valid), 32'h0);
    check("lsu_rst_mask",  32'(bus.issued_mask), 32'h0);
    check("lsu_rst_wfid",  32'(bus.issue_wfid),  32'h0);
    rst = 1'b0;
    step();
    check("lsu_post_valid", 32'(bus.issue_valid), 32'b0100);
    check("lsu_post_wfid",  32'(wfid(FU_LSU)),    32'd3);

    // Grant of slot 7 wraps the SALU pointer to 0.
    do_reset();
    set_slot(7, ISSUE_FU_SALU_ENCODING);
    bus.wf_ready = 8'h80;
    bus.fu_ready = 4'hF;
    step();
    check("wrap_first_wfid", 32'(wfid(FU_SALU)), 32'd7);
    bus.wf_ready = 8'h00;
    step();
    set_slot(0, ISSUE_FU_SALU_ENCODING);
    bus.wf_ready = 8'h81;
    step();
    check("wrap_valid", 32'(bus.issue_valid), 32'b0010);
    check("wrap_wfid0", 32'(wfid(FU_SALU)),   32'd0);
    step();
    check("wrap_wfid7", 32'(wfid(FU_SALU)),   32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
